// File: rtl/spwm_3phase_gen.sv
// Three-phase sine-PWM gate generator: 48-step sine table, triangle carrier,
// per-leg complementary gates with dead time.
module spwm_3phase_gen #(
    parameter int unsigned CARRIER_MAX = 255,
    parameter int unsigned DEAD_TIME   = 8
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       step_in,
    input  logic       enable,
    input  logic [7:0] mod_index,
    output logic       gate_ah,
    output logic       gate_al,
    output logic       gate_bh,
    output logic       gate_bl,
    output logic       gate_ch,
    output logic       gate_cl,
    output logic [5:0] step_idx,
    output logic       sync_out,
    output logic [5:0] o_leg_state
);

    typedef enum logic [1:0] {
        LEG_OFF  = 2'd0,
        LEG_DEAD = 2'd1,
        LEG_HI   = 2'd2,
        LEG_LO   = 2'd3
    } leg_state_t;

    localparam logic [7:0] C_MAX  = 8'(CARRIER_MAX);
    localparam logic [7:0] D_LAST = 8'(DEAD_TIME - 1);

    // round(128 + 127*sin(2*pi*k/48)), rounding the sine term half away from zero
    function automatic logic [7:0] sine_rom(input logic [5:0] k);
        logic [7:0] v;
        case (k)
            6'd0:  v = 8'd128; 6'd1:  v = 8'd145; 6'd2:  v = 8'd161; 6'd3:  v = 8'd177;
            6'd4:  v = 8'd192; 6'd5:  v = 8'd205; 6'd6:  v = 8'd218; 6'd7:  v = 8'd229;
            6'd8:  v = 8'd238; 6'd9:  v = 8'd245; 6'd10: v = 8'd251; 6'd11: v = 8'd254;
            6'd12: v = 8'd255; 6'd13: v = 8'd254; 6'd14: v = 8'd251; 6'd15: v = 8'd245;
            6'd16: v = 8'd238; 6'd17: v = 8'd229; 6'd18: v = 8'd218; 6'd19: v = 8'd205;
            6'd20: v = 8'd192; 6'd21: v = 8'd177; 6'd22: v = 8'd161; 6'd23: v = 8'd145;
            6'd24: v = 8'd128; 6'd25: v = 8'd111; 6'd26: v = 8'd95;  6'd27: v = 8'd79;
            6'd28: v = 8'd64;  6'd29: v = 8'd51;  6'd30: v = 8'd38;  6'd31: v = 8'd27;
            6'd32: v = 8'd18;  6'd33: v = 8'd11;  6'd34: v = 8'd5;   6'd35: v = 8'd2;
            6'd36: v = 8'd1;   6'd37: v = 8'd2;   6'd38: v = 8'd5;   6'd39: v = 8'd11;
            6'd40: v = 8'd18;  6'd41: v = 8'd27;  6'd42: v = 8'd38;  6'd43: v = 8'd51;
            6'd44: v = 8'd64;  6'd45: v = 8'd79;  6'd46: v = 8'd95;  6'd47: v = 8'd111;
            default: v = 8'd128;
        endcase
        return v;
    endfunction

    function automatic logic [7:0] scale(input logic [7:0] s, input logic [7:0] m);
        logic signed [16:0] diff;
        logic signed [16:0] prod;
        logic signed [16:0] shr;
        diff = $signed({9'b0, s}) - 17'sd128;
        prod = diff * $signed({9'b0, m});
        shr  = prod >>> 8;
        return 8'(shr + 17'sd128);
    endfunction

    logic       r_step_q;
    logic [5:0] r_idx;
    logic       r_sync;
    logic [7:0] r_carrier;
    logic       r_up;
    logic [7:0] r_duty [3];
    leg_state_t r_state [3];
    logic [7:0] r_dead_cnt [3];
    logic [2:0] r_gh;
    logic [2:0] r_gl;

    logic       w_step_edge;
    logic [5:0] w_kb;
    logic [5:0] w_kc;
    logic [2:0] w_want;

    assign w_step_edge = step_in & ~r_step_q;
    assign w_kb = (r_idx >= 6'd32) ? r_idx - 6'd32 : r_idx + 6'd16;
    assign w_kc = (r_idx >= 6'd16) ? r_idx - 6'd16 : r_idx + 6'd32;

    always_comb begin
        w_want = 3'b000;
        for (int i = 0; i < 3; i++) begin
            w_want[i] = (r_duty[i] > r_carrier);
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_step_q <= 1'b0;
            r_idx    <= 6'd0;
            r_sync   <= 1'b0;
        end else begin
            r_step_q <= step_in;
            r_sync   <= w_step_edge && (r_idx == 6'd47);
            if (w_step_edge) begin
                r_idx <= (r_idx == 6'd47) ? 6'd0 : r_idx + 6'd1;
            end
        end
    end

    // Duties reload only at the carrier valley so a pulse is never cut mid-period.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_carrier <= 8'd0;
            r_up      <= 1'b1;
            for (int i = 0; i < 3; i++) begin
                r_duty[i] <= 8'd128;
            end
        end else begin
            if (r_up) begin
                if (r_carrier == C_MAX) begin
                    r_up      <= 1'b0;
                    r_carrier <= r_carrier - 8'd1;
                end else begin
                    r_carrier <= r_carrier + 8'd1;
                end
            end else begin
                if (r_carrier == 8'd0) begin
                    r_up      <= 1'b1;
                    r_carrier <= 8'd1;
                end else begin
                    r_carrier <= r_carrier - 8'd1;
                end
            end
            if (r_carrier == 8'd0) begin
                r_duty[0] <= scale(sine_rom(r_idx), mod_index);
                r_duty[1] <= scale(sine_rom(w_kb), mod_index);
                r_duty[2] <= scale(sine_rom(w_kc), mod_index);
            end
        end
    end

    // Gates are set on the same edge as the state they belong to, so the
    // both-off window starts on the edge where the compare flips.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                r_state[i]    <= LEG_OFF;
                r_dead_cnt[i] <= 8'd0;
            end
            r_gh <= 3'b000;
            r_gl <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!enable) begin
                    r_state[i] <= LEG_OFF;
                    r_gh[i]    <= 1'b0;
                    r_gl[i]    <= 1'b0;
                end else begin
                    case (r_state[i])
                        LEG_OFF: begin
                            r_state[i]    <= LEG_DEAD;
                            r_dead_cnt[i] <= 8'd0;
                            r_gh[i]       <= 1'b0;
                            r_gl[i]       <= 1'b0;
                        end
                        LEG_DEAD: begin
                            if (r_dead_cnt[i] == D_LAST) begin
                                r_state[i] <= w_want[i] ? LEG_HI : LEG_LO;
                                r_gh[i]    <= w_want[i];
                                r_gl[i]    <= ~w_want[i];
                            end else begin
                                r_dead_cnt[i] <= r_dead_cnt[i] + 8'd1;
                            end
                        end
                        LEG_HI: begin
                            if (!w_want[i]) begin
                                r_state[i]    <= LEG_DEAD;
                                r_dead_cnt[i] <= 8'd0;
                                r_gh[i]       <= 1'b0;
                            end
                        end
                        LEG_LO: begin
                            if (w_want[i]) begin
                                r_state[i]    <= LEG_DEAD;
                                r_dead_cnt[i] <= 8'd0;
                                r_gl[i]       <= 1'b0;
                            end
                        end
                        default: begin
                            r_state[i] <= LEG_OFF;
                            r_gh[i]    <= 1'b0;
                            r_gl[i]    <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign gate_ah     = r_gh[0];
    assign gate_al     = r_gl[0];
    assign gate_bh     = r_gh[1];
    assign gate_bl     = r_gl[1];
    assign gate_ch     = r_gh[2];
    assign gate_cl     = r_gl[2];
    assign step_idx    = r_idx;
    assign sync_out    = r_sync;
    assign o_leg_state = {r_state[2], r_state[1], r_state[0]};

endmodule

// File: tb/tb_spwm_3phase_gen.sv
// Bench for spwm_3phase_gen: cycle-exact comparison against a time-based
// reference model (carrier from a cycle count, sine from $sin).
module tb_spwm_3phase_gen;

    localparam int CARRIER_MAX = 255;
    localparam int DEAD_TIME   = 8;
    localparam int PERIOD      = 2 * CARRIER_MAX;

    logic       clk_in = 1'b0;
    logic       reset;
    logic       step_in;
    logic       enable;
    logic [7:0] mod_index;
    logic       gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl;
    logic [5:0] step_idx;
    logic       sync_out;
    logic [5:0] leg_state;

    int vectors     = 0;
    int miscompares = 0;

    spwm_3phase_gen #(.CARRIER_MAX(CARRIER_MAX), .DEAD_TIME(DEAD_TIME)) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .step_in    (step_in),
        .enable     (enable),
        .mod_index  (mod_index),
        .gate_ah    (gate_ah),
        .gate_al    (gate_al),
        .gate_bh    (gate_bh),
        .gate_bl    (gate_bl),
        .gate_ch    (gate_ch),
        .gate_cl    (gate_cl),
        .step_idx   (step_idx),
        .sync_out   (sync_out),
        .o_leg_state(leg_state)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_t, m_idx, m_stepq, m_sync;
    int m_duty [3];
    int m_on   [3];
    int m_drv  [3];   // +1 high gate, -1 low gate, 0 both off
    int m_dead [3];   // cycles left in the both-off window

    function automatic int tri_of(input int t);
        return (t <= CARRIER_MAX) ? t : PERIOD - t;
    endfunction

    function automatic int sine_of(input int k);
        real v;
        int  r;
        v = 127.0 * $sin(2.0 * 3.14159265358979 * k / 48.0);
        if (v >= 0.0) r = int'($floor(v + 0.5 + 1.0e-6));
        else          r = -int'($floor(-v + 0.5 + 1.0e-6));
        return 128 + r;
    endfunction

    function automatic int duty_of(input int s, input int m);
        int p;
        p = (s - 128) * m;
        if (p >= 0) return 128 + p / 256;
        return 128 - (-p + 255) / 256;
    endfunction

    function automatic int model_gates();
        int g;
        g = 0;
        for (int p = 0; p < 3; p++) begin
            g = (g << 2) | ((m_drv[p] == 1) ? 2 : 0) | ((m_drv[p] == -1) ? 1 : 0);
        end
        return g;
    endfunction

    always @(posedge clk_in or posedge reset) begin
        int  c;
        bit  want;
        bit  edge_seen;
        if (reset) begin
            m_t = 0; m_idx = 0; m_stepq = 0; m_sync = 0;
            for (int p = 0; p < 3; p++) begin
                m_duty[p] = 128; m_on[p] = 0; m_drv[p] = 0; m_dead[p] = 0;
            end
        end else begin
            c = tri_of(m_t);
            for (int p = 0; p < 3; p++) begin
                want = (m_duty[p] > c);
                if (!enable) begin
                    m_on[p] = 0; m_drv[p] = 0;
                end else if (m_on[p] == 0) begin
                    m_on[p] = 1; m_drv[p] = 0; m_dead[p] = DEAD_TIME;
                end else if (m_drv[p] == 0) begin
                    m_dead[p]--;
                    if (m_dead[p] == 0) m_drv[p] = want ? 1 : -1;
                end else if ((m_drv[p] == 1) != want) begin
                    m_drv[p] = 0; m_dead[p] = DEAD_TIME;
                end
            end
            if (c == 0) begin
                for (int p = 0; p < 3; p++) begin
                    m_duty[p] = duty_of(sine_of((m_idx + 16 * p) % 48), int'(mod_index));
                end
            end
            edge_seen = (step_in == 1'b1) && (m_stepq == 0);
            m_sync    = (edge_seen && m_idx == 47) ? 1 : 0;
            if (edge_seen) m_idx = (m_idx + 1) % 48;
            m_stepq = int'(step_in);
            m_t     = (m_t + 1) % PERIOD;
        end
    end

    // ---------------- drivers / comparison ----------------
    function automatic int dut_gates();
        return int'({gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl});
    endfunction

    task automatic compare_outputs();
        check("gates", dut_gates(), model_gates());
        check("step_idx", int'(step_idx), m_idx);
        check("sync_out", int'(sync_out), m_sync);
        check("hl_overlap", int'((gate_ah & gate_al) | (gate_bh & gate_bl) | (gate_ch & gate_cl)), 0);
    endtask

    task automatic tick();
        @(negedge clk_in);
        compare_outputs();
    endtask

    int  sync_count;
    int  run_len;
    bit  seen_on;
    bit  found;

    initial begin
        reset = 1'b1; step_in = 1'b0; enable = 1'b0; mod_index = 8'd0;
        repeat (3) @(negedge clk_in);
        check("reset_gates", dut_gates(), 0);
        check("reset_idx", int'(step_idx), 0);
        check("reset_sync", int'(sync_out), 0);
        reset = 1'b0;

        // 48 step edges with the bridge disabled
        sync_count = 0;
        for (int n = 0; n < 48; n++) begin
            step_in = 1'b1;
            tick();
            if (sync_out) sync_count++;
            check("dis_gates", dut_gates(), 0);
            step_in = 1'b0;
            tick();
            if (sync_out) sync_count++;
        end
        check("wrap_sync_count", sync_count, 1);
        check("wrap_idx", int'(step_idx), 0);

        // mod_index 0: 50% legs, dead window measured on leg A
        enable = 1'b1; mod_index = 8'd0;
        run_len = 0; seen_on = 1'b0;
        for (int n = 0; n < 3 * PERIOD; n++) begin
            tick();
            if (gate_ah | gate_al) begin
                if (seen_on && run_len > 0) check("dead_run", run_len, DEAD_TIME);
                run_len = 0; seen_on = 1'b1;
            end else begin
                run_len++;
            end
        end

        // full modulation at idx 0
        mod_index = 8'd255;
        for (int n = 0; n < 2 * PERIOD + 20; n++) tick();

        // drop enable while leg A is driving high, then re-enable
        found = 1'b0;
        for (int n = 0; n < 2 * PERIOD && !found; n++) begin
            tick();
            if (gate_ah) found = 1'b1;
        end
        check("wait_gate_ah", int'(found), 1);
        enable = 1'b0;
        tick();
        check("en_drop_gates", dut_gates(), 0);
        check("en_drop_state", int'(leg_state), 0);
        enable = 1'b1;
        for (int n = 0; n < DEAD_TIME; n++) begin
            tick();
            check("reen_dead", dut_gates(), 0);
        end
        tick();
        check("reen_gate_on", int'(gate_ah | gate_al), 1);

        // randomized run with one asynchronous reset in the middle
        for (int n = 0; n < 40000; n++) begin
            tick();
            if (n == 20000) begin
                #2 reset = 1'b1;
                #1;
                check("async_rst_gates", dut_gates(), 0);
                check("async_rst_idx", int'(step_idx), 0);
                repeat (2) @(negedge clk_in);
                reset = 1'b0;
                compare_outputs();
            end
            if ((n % 2000) == 0) mod_index = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) step_in = ~step_in;
            if (enable) begin
                if ($urandom_range(0, 2999) == 0) enable = 1'b0;
            end else begin
                if ($urandom_range(0, 99) == 0) enable = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
